// File: rtl/freq_tick_gen_if.sv
// Request and status bundle between freq_tick_gen and its controller.
// The controller holds the master modport and the tick generator holds the slave modport.
interface freq_tick_gen_if #(
  parameter int unsigned COUNT_W = 16
);
  logic [5:0]         div_in;
  logic [2:0]         sel;
  logic               sel_load;
  logic               clr_count;
  logic               tick;
  logic [COUNT_W-1:0] tick_count;
  logic [2:0]         sel_cur;
  logic               busy;
  logic               sel_err;

  modport master (
    output div_in, sel, sel_load, clr_count,
    input  tick, tick_count, sel_cur, busy, sel_err
  );

  modport slave (
    input  div_in, sel, sel_load, clr_count,
    output tick, tick_count, sel_cur, busy, sel_err
  );
endinterface

// File: rtl/freq_tick_gen.sv
// Resynchronises the ripple-divider taps and emits one clk-wide tick per rising edge of the selected tap.
// Each tap switch passes through a settle window that suppresses ticks.
module freq_tick_gen #(
  parameter int unsigned SETTLE    = 4,
  parameter int unsigned COUNT_W   = 16,
  parameter int unsigned RESET_SEL = 0
) (
  input  logic            clk,
  input  logic            reset,
  freq_tick_gen_if.slave  bus_if
);

  localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE - 1);
  localparam logic [2:0]       SEL_INIT    = 3'(RESET_SEL);

  typedef enum logic {
    ST_SETTLE,
    ST_RUN
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic [2:0]         sel_cur_q, sel_cur_d;
  logic [5:0]         s1_q, s2_q, s3_q;
  logic               tick_q, tick_d;
  logic               sel_err_q, sel_err_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               load_ok, load_bad, rise;

  assign load_ok  = bus_if.sel_load & (bus_if.sel <= 3'd5);
  assign load_bad = bus_if.sel_load & (bus_if.sel >  3'd5);
  assign rise     = s2_q[sel_cur_q] & ~s3_q[sel_cur_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_SETTLE;
      settle_cnt_q <= SETTLE_INIT;
      sel_cur_q    <= SEL_INIT;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      sel_cur_q    <= sel_cur_d;
    end
  end

  // A valid load restarts the settle window from any state, even mid-settle.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    sel_cur_d    = sel_cur_q;
    if (load_ok) begin
      sel_cur_d    = bus_if.sel;
      settle_cnt_d = SETTLE_INIT;
      state_d      = ST_SETTLE;
    end else begin
      unique case (state_q)
        ST_SETTLE: begin
          if (settle_cnt_q == '0) state_d = ST_RUN;
          else                    settle_cnt_d = settle_cnt_q - 1'b1;
        end
        ST_RUN: ;
        default: state_d = ST_SETTLE;
      endcase
    end
  end

  always_comb begin
    bus_if.busy = (state_q == ST_SETTLE);
  end

  always_comb begin
    tick_d    = rise & (state_q == ST_RUN) & ~load_ok;
    sel_err_d = load_bad;
    count_d   = count_q;
    if (bus_if.clr_count) count_d = '0;
    else if (tick_d)      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      tick_q    <= 1'b0;
      sel_err_q <= 1'b0;
      count_q   <= '0;
    end else begin
      s1_q      <= bus_if.div_in;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      tick_q    <= tick_d;
      sel_err_q <= sel_err_d;
      count_q   <= count_d;
    end
  end

  assign bus_if.tick       = tick_q;
  assign bus_if.sel_err    = sel_err_q;
  assign bus_if.tick_count = count_q;
  assign bus_if.sel_cur    = sel_cur_q;

endmodule

// File: tb/tb_freq_tick_gen.sv
// Randomised bench for freq_tick_gen: it compares the outputs every cycle against a model
// built from the sampled-history rules, with a free-running divider and random taps as input.
module tb_freq_tick_gen;

  localparam int unsigned SETTLE    = 4;
  localparam int unsigned CW        = 4;
  localparam int unsigned RESET_SEL = 0;
  localparam int          NCYC      = 4000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  freq_tick_gen_if #(.COUNT_W(CW)) bus_if ();

  freq_tick_gen #(
    .SETTLE   (SETTLE),
    .COUNT_W  (CW),
    .RESET_SEL(RESET_SEL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus_if(bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp, input int cyc);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Model: div_in as sampled at each edge; a tap rise at edge e needs 1 at e-2 and 0 at e-3.
  logic [5:0] hist[$];
  int         m_rem, m_sel, m_count;
  logic       m_tick, m_err;

  task automatic model_step(input logic r, input logic ld, input logic [2:0] sl,
                            input logic clr, input logic [5:0] dv);
    logic [5:0] a, b;
    logic       rise, run;
    if (r) begin
      hist    = {6'h0, 6'h0, 6'h0};
      m_rem   = SETTLE;
      m_sel   = RESET_SEL;
      m_count = 0;
      m_tick  = 1'b0;
      m_err   = 1'b0;
    end else begin
      a    = hist[hist.size()-2];
      b    = hist[hist.size()-3];
      rise = a[m_sel] & ~b[m_sel];
      run  = (m_rem == 0);
      if (ld && sl <= 3'd5) begin
        m_sel  = int'(sl);
        m_rem  = SETTLE;
        m_tick = 1'b0;
      end else begin
        m_tick = run && rise;
        if (m_rem > 0) m_rem--;
      end
      m_err = ld && (sl > 3'd5);
      if (clr)         m_count = 0;
      else if (m_tick) m_count = (m_count + 1) % (1 << CW);
      hist.push_back(dv);
      void'(hist.pop_front());
    end
  endtask

  initial begin
    logic [5:0] divcnt;
    logic       r, ld, clr;
    logic [2:0] sl;
    logic [5:0] dv;
    divcnt = '0;
    hist   = {6'h0, 6'h0, 6'h0};
    m_rem = SETTLE; m_sel = RESET_SEL; m_count = 0; m_tick = 0; m_err = 0;
    reset = 1'b1;
    bus_if.div_in = '0; bus_if.sel = '0; bus_if.sel_load = 1'b0; bus_if.clr_count = 1'b0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      r   = (cyc < 2) || ($urandom_range(0, 599) == 0);
      ld  = ($urandom_range(0, 59) == 0);
      sl  = 3'($urandom_range(0, 7));
      clr = ($urandom_range(0, 249) == 0);
      if (((cyc / 256) % 4) == 3) dv = 6'($urandom);
      else                        dv = divcnt;
      divcnt = divcnt + 6'd1;
      case (cyc)
        60:  begin ld = 1'b1; sl = 3'd3; end
        160: begin ld = 1'b1; sl = 3'd6; end
        220: begin ld = 1'b1; sl = 3'd5; end
        222: begin ld = 1'b1; sl = 3'd1; end
        300: begin ld = 1'b1; sl = 3'd0; end
        340: clr = 1'b1;
        420: r = 1'b1;
        default: ;
      endcase
      if (cyc > 160 && cyc < 240 && cyc != 220 && cyc != 222) ld = 1'b0;

      reset            = r;
      bus_if.sel_load  = ld;
      bus_if.sel       = sl;
      bus_if.clr_count = clr;
      bus_if.div_in    = dv;

      @(posedge clk);
      model_step(r, ld, sl, clr, dv);
      #1;
      check_eq("tick",       32'(bus_if.tick),       32'(m_tick),  cyc);
      check_eq("tick_count", 32'(bus_if.tick_count), 32'(m_count), cyc);
      check_eq("sel_cur",    32'(bus_if.sel_cur),    32'(m_sel),   cyc);
      check_eq("busy",       32'(bus_if.busy),       32'(m_rem > 0), cyc);
      check_eq("sel_err",    32'(bus_if.sel_err),    32'(m_err),   cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
